// File: rtl/piso_shift_tx_if.sv
// -----------------------------------------------------------------------------
// piso_shift_tx_if
//   Load handshake and serial-stream bundle for the PISO shift transmitter.
//   master : the word producer / stream consumer (drives din, load_valid)
//   slave  : the transmitter itself
// Signals
//   din         WIDTH  parallel word to transmit
//   load_valid  1      din valid
//   load_ready  1      transmitter idle, can accept a word
//   sout        1      serial data out
//   sout_valid  1      high while sout carries a word bit
//   tick        1      one-cycle bit-period strobe for downstream sampling
//   done        1      one-cycle pulse after the last bit period of a word
// -----------------------------------------------------------------------------
interface piso_shift_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             load_valid;
  logic             load_ready;
  logic             sout;
  logic             sout_valid;
  logic             tick;
  logic             done;

  modport master (
    output din, load_valid,
    input  load_ready, sout, sout_valid, tick, done
  );

  modport slave (
    input  din, load_valid,
    output load_ready, sout, sout_valid, tick, done
  );
endinterface

// File: rtl/piso_shift_tx.sv
// -----------------------------------------------------------------------------
// piso_shift_tx
//   Parallel-in, serial-out shift transmitter. Takes a WIDTH-bit word over a
//   valid/ready handshake and shifts it out one bit per TICK_DIV enabled clock
//   cycles. The bit-period strobe is exported as tick so the receiving stage
//   samples sout on the same strobe that advances the shifter.
// Parameters
//   WIDTH      bits per word (>=2)
//   TICK_DIV   enabled clk cycles per bit period (>=2)
//   MSB_FIRST  1: din[WIDTH-1] sent first, 0: din[0] sent first
// Ports
//   clk   in  system clock, all logic on posedge
//   rst   in  asynchronous, active-high reset
//   en    in  global enable; 0 freezes divider and shifting
//   bus   slave side of piso_shift_tx_if (din, load_valid, load_ready,
//         sout, sout_valid, tick, done)
// -----------------------------------------------------------------------------
module piso_shift_tx #(
  parameter int WIDTH     = 8,
  parameter int TICK_DIV  = 100_000_000,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  piso_shift_tx_if.slave bus
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Terminal count is flagged one cycle ahead so the flag itself is a
  // register that is high exactly while cnt == TICK_DIV-1.
  localparam logic [CNT_W-1:0] CNT_PRE_LAST = CNT_W'(TICK_DIV - 2);
  localparam logic [BIT_W-1:0] BIT_LAST     = BIT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] shreg;
  logic             term_q;   // cnt is at TICK_DIV-1 this cycle
  logic             done_q;

  // NOTE: every register below, shreg included, sits in the async reset
  // branch: sout is taken straight from shreg, so the datapath must come up
  // clean, not just the control state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      term_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so the default below is simply
      // overridden by a later assignment in the same edge.
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          // A word is never taken while disabled; load_ready stays high.
          if (bus.load_valid && en) begin
            shreg   <= bus.din;
            bit_cnt <= '0;
            cnt     <= '0;
            term_q  <= 1'b0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          // load_valid is ignored here; en=0 freezes cnt, bit and bit_cnt.
          if (en) begin
            if (term_q) begin
              // This edge consumes the tick: the current bit has been held
              // for TICK_DIV enabled cycles.
              cnt    <= '0;
              term_q <= 1'b0;
              if (bit_cnt == BIT_LAST) begin
                state   <= IDLE;
                shreg   <= '0;          // drives sout low in IDLE
                bit_cnt <= '0;
                done_q  <= 1'b1;
              end else begin
                shreg   <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              cnt    <= cnt + 1'b1;
              term_q <= (cnt == CNT_PRE_LAST);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.load_ready = (state == IDLE);
  assign bus.sout_valid = (state == SHIFT);
  assign bus.sout       = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
  assign bus.done       = done_q;
  // The registered terminal-count flag is qualified by en so no strobe is
  // seen downstream on a frozen cycle; the shifter only consumes it when en=1.
  assign bus.tick       = term_q & en;

endmodule

// File: tb/tb_piso_shift_tx.sv
// -----------------------------------------------------------------------------
// tb_piso_shift_tx
//   Self-checking bench for piso_shift_tx (WIDTH=8, TICK_DIV=4). Two instances
//   share clk/rst/en: one MSB-first, one LSB-first. Inputs change on the
//   falling edge; outputs are sampled 1 ns later. Expected values come from a
//   position-based model: after an accept, the n-th enabled cycle shows word
//   bit n/TICK_DIV, tick fires on the last enabled cycle of each bit period,
//   and done follows the WIDTH*TICK_DIV-th enabled cycle.
// -----------------------------------------------------------------------------
module tb_piso_shift_tx;

  localparam int WIDTH = 8;
  localparam int TD    = 4;
  localparam int NCYC  = WIDTH * TD;

  logic clk = 1'b0;
  logic rst;
  logic en;

  piso_shift_tx_if #(.WIDTH(WIDTH)) m_if ();
  piso_shift_tx_if #(.WIDTH(WIDTH)) l_if ();

  piso_shift_tx #(.WIDTH(WIDTH), .TICK_DIV(TD), .MSB_FIRST(1'b1)) dut_msb (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .bus (m_if.slave)
  );

  piso_shift_tx #(.WIDTH(WIDTH), .TICK_DIV(TD), .MSB_FIRST(1'b0)) dut_lsb (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .bus (l_if.slave)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // k-th transmitted bit of word w
  function automatic logic ref_bit(input logic [WIDTH-1:0] w, input int k,
                                   input bit msb_first);
    return msb_first ? w[WIDTH-1-k] : w[k];
  endfunction

  // {sout, sout_valid, tick, load_ready, done}
  function automatic logic [4:0] obs_m();
    return {m_if.sout, m_if.sout_valid, m_if.tick, m_if.load_ready, m_if.done};
  endfunction

  function automatic logic [4:0] obs_l();
    return {l_if.sout, l_if.sout_valid, l_if.tick, l_if.load_ready, l_if.done};
  endfunction

  // Sends one word on the MSB-first instance and checks every cycle. Optional
  // en stall (stall_len cycles at position stall_pos) and optional one-cycle
  // load_valid pulse with 8'h00 at position inj_pos (-1 disables either).
  task automatic drive_word(input string name, input logic [WIDTH-1:0] w,
                            input int stall_pos, input int stall_len,
                            input int inj_pos);
    int         pos;
    int         stalled;
    bit         en_c;
    logic [4:0] o;
    logic [4:0] e;
    en = 1'b1;
    m_if.din = w;
    m_if.load_valid = 1'b1;
    #1;
    tests_run++;
    if (m_if.load_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s ready_before_accept: got %b expected 1", name, m_if.load_ready);
    end
    @(negedge clk);
    m_if.load_valid = 1'b0;
    pos = 0;
    stalled = 0;
    while (pos < NCYC) begin
      en_c = !((pos == stall_pos) && (stalled < stall_len));
      if (!en_c) stalled++;
      en = en_c;
      m_if.load_valid = (pos == inj_pos);
      m_if.din = (pos == inj_pos) ? 8'h00 : w;
      #1;
      e = {ref_bit(w, pos / TD, 1'b1), 1'b1, en_c && (pos % TD == TD - 1), 1'b0, 1'b0};
      o = obs_m();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL %s pos=%0d en=%0b {sout,valid,tick,ready,done}: got %b expected %b",
                 name, pos, en_c, o, e);
      end
      if (en_c) pos++;
      @(negedge clk);
    end
    en = 1'b1;
    m_if.load_valid = 1'b0;
    #1;
    tests_run++;
    if (obs_m() !== 5'b00011) begin
      tests_failed++;
      $display("FAIL %s done_cycle: got %b expected 00011", name, obs_m());
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (obs_m() !== 5'b00010) begin
      tests_failed++;
      $display("FAIL %s after_done: got %b expected 00010", name, obs_m());
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en = 1'b1;
    m_if.din = '0;
    m_if.load_valid = 1'b0;
    l_if.din = '0;
    l_if.load_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if (obs_m() !== 5'b00010) begin
      tests_failed++;
      $display("FAIL reset_state_msb: got %b expected 00010", obs_m());
    end
    tests_run++;
    if (obs_l() !== 5'b00010) begin
      tests_failed++;
      $display("FAIL reset_state_lsb: got %b expected 00010", obs_l());
    end
    rst = 1'b0;
    @(negedge clk);
    // Start a word, then reset asynchronously between clock edges mid-word.
    m_if.din = 8'($urandom) | 8'h80;
    m_if.load_valid = 1'b1;
    @(negedge clk);
    m_if.load_valid = 1'b0;
    repeat (9) @(negedge clk);
    tests_run++;
    if (m_if.sout_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_pre_midword_valid: got %b expected 1", m_if.sout_valid);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (obs_m() !== 5'b00010) begin
      tests_failed++;
      $display("FAIL reset_async_midword: got %b expected 00010", obs_m());
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < NCYC + 8; c++) begin
      #1;
      tests_run++;
      if (m_if.done !== 1'b0 || m_if.sout_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_no_done c=%0d: got done=%b valid=%b expected 0 0",
                 c, m_if.done, m_if.sout_valid);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_single_word();
    drive_word("single_A5", 8'hA5, -1, 0, -1);
  endtask

  task automatic test_lsb_first();
    logic [WIDTH-1:0] words [2];
    logic [4:0]       e;
    words[0] = 8'h01;
    words[1] = 8'($urandom);
    foreach (words[i]) begin
      en = 1'b1;
      l_if.din = words[i];
      l_if.load_valid = 1'b1;
      @(negedge clk);
      l_if.load_valid = 1'b0;
      for (int pos = 0; pos < NCYC; pos++) begin
        #1;
        e = {ref_bit(words[i], pos / TD, 1'b0), 1'b1, (pos % TD == TD - 1), 1'b0, 1'b0};
        tests_run++;
        if (obs_l() !== e) begin
          tests_failed++;
          $display("FAIL lsb_first w=%h pos=%0d: got %b expected %b",
                   words[i], pos, obs_l(), e);
        end
        @(negedge clk);
      end
      #1;
      tests_run++;
      if (obs_l() !== 5'b00011) begin
        tests_failed++;
        $display("FAIL lsb_first_done w=%h: got %b expected 00011", words[i], obs_l());
      end
      @(negedge clk);
    end
  endtask

  // load_valid held high: FF accepted, then 00 accepted in the done cycle.
  task automatic test_back_to_back();
    logic [2:0] e;
    logic [2:0] o;
    en = 1'b1;
    m_if.din = 8'hFF;
    m_if.load_valid = 1'b1;
    @(negedge clk);
    m_if.din = 8'h00;
    for (int c = 1; c <= 2 * NCYC + 2; c++) begin
      if (c == NCYC + 2) m_if.load_valid = 1'b0;
      #1;
      if (c <= NCYC)            e = 3'b110;
      else if (c == NCYC + 1)   e = 3'b001;
      else if (c <= 2*NCYC + 1) e = 3'b010;
      else                      e = 3'b001;
      o = {m_if.sout, m_if.sout_valid, m_if.done};
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL back_to_back c=%0d {sout,valid,done}: got %b expected %b", c, o, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_enable_stall();
    // position 13 lies inside bit 3 (positions 12..15)
    drive_word("stall_3C", 8'h3C, 13, 10, -1);
  endtask

  task automatic test_ignore_in_shift();
    drive_word("ignore_F0", 8'hF0, -1, 0, 10);
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] w;
    int               sp;
    int               sl;
    int               ip;
    for (int n = 0; n < 6; n++) begin
      w  = 8'($urandom);
      sp = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NCYC - 1)) : -1;
      sl = int'($urandom_range(1, 6));
      ip = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NCYC - 1)) : -1;
      drive_word("random", w, sp, sl, ip);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_lsb_first();
    test_back_to_back();
    test_enable_stall();
    test_ignore_in_shift();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
